// File: rtl/rf_dump_reader_if.sv
// Dump stream for rf_dump_reader: one (address, value, last) beat per valid/ready handshake.
interface rf_dump_reader_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              dump_last;

  modport master (
    output dump_valid, dump_addr, dump_data, dump_last,
    input  dump_ready
  );

  modport slave (
    input  dump_valid, dump_addr, dump_data, dump_last,
    output dump_ready
  );
endinterface

// File: rtl/rf_dump_reader.sv
// Walks RF addresses 0..NUM_REGS-1 on one read port and streams (addr, data) beats out.
// Optional RF_DUMP_SKIP_ZERO_EN: registers reading zero produce no beat.
module rf_dump_reader #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [DATA_W-1:0]    rd_data,
  output logic                 done,
  rf_dump_reader_if.master     dump
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    HOLD,
    FINISH
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic              skip;

`ifdef RF_DUMP_SKIP_ZERO_EN
  assign skip = (rd_data == '0);
`else
  assign skip = 1'b0;
`endif

  // idx is a register, so the read address is registered too
  assign rd_addr = idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      idx             <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      dump.dump_valid <= 1'b0;
      dump.dump_addr  <= '0;
      dump.dump_data  <= '0;
      dump.dump_last  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            idx   <= '0;
            busy  <= 1'b1;
            state <= READ;
          end
        end

        READ: begin
          if (skip) begin
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= FINISH;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            dump.dump_valid <= 1'b1;
            dump.dump_addr  <= idx;
            dump.dump_data  <= rd_data;
            dump.dump_last  <= (idx == LAST_IDX);
            state           <= HOLD;
          end
        end

        HOLD: begin
          if (dump.dump_ready) begin
            dump.dump_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              idx   <= '0;
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              idx   <= idx + 1'b1;
              state <= READ;
            end
          end
        end

        FINISH: begin
          // Entered from a skipped last register with done still low: raise it for one cycle first
          if (done) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_dump_reader.sv
// Self-checking bench for rf_dump_reader: table of dump scenarios plus reset/restart sequences.
module tb_rf_dump_reader;

  localparam int NR = 32;

`ifdef RF_DUMP_SKIP_ZERO_EN
  localparam bit          SKIP       = 1'b1;
  localparam int unsigned FULL_FIRST = 3;
  localparam int unsigned FULL_DONE  = 64;
  localparam int unsigned SP_FIRST   = 5;
  localparam int unsigned SP_DONE    = 35;
  localparam int unsigned Z_FIRST    = 0;
  localparam int unsigned Z_DONE     = 34;
`else
  localparam bit          SKIP       = 1'b0;
  localparam int unsigned FULL_FIRST = 2;
  localparam int unsigned FULL_DONE  = 65;
  localparam int unsigned SP_FIRST   = 2;
  localparam int unsigned SP_DONE    = 65;
  localparam int unsigned Z_FIRST    = 2;
  localparam int unsigned Z_DONE     = 65;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] rf [NR];

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    string       name;
    int unsigned fill;       // 0: i*0x11, 1: random, 2: only r3/r31, 3: all zero
    int unsigned ready_pct;
    int unsigned restart_at; // cycle of a second start pulse, 0 = none
    bit          wr;         // write r6 while addr 5 is being read
    int unsigned exp_first;  // 0 = unchecked
    int unsigned exp_done;   // 0 = unchecked
  } vec_t;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    logic        l;
  } beat_t;

  beat_t expq[$];
  vec_t  tbl[8];

  rf_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) dif ();

  rf_dump_reader #(.ADDR_W(5), .DATA_W(32), .NUM_REGS(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .busy    (busy),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .done    (done),
    .dump    (dif)
  );

  always #5 clk = ~clk;

  assign rd_data = rf[rd_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fill(input int unsigned mode);
    for (int i = 0; i < NR; i++) begin
      case (mode)
        0:       rf[i] = i * 32'h11;
        1:       rf[i] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
        default: rf[i] = 32'h0;
      endcase
    end
    if (mode == 2) begin
      rf[3]  = 32'hA;
      rf[31] = 32'hB;
    end
    rf[0] = 32'h0;
  endtask

  // Expected beat list straight from the register contents.
  task automatic build_exp(input bit wr);
    logic [31:0] snap [NR];
    expq.delete();
    for (int i = 0; i < NR; i++) snap[i] = rf[i];
    if (wr) snap[6] = 32'hDEADBEEF;
    for (int i = 0; i < NR; i++)
      if (!(SKIP && snap[i] == 32'h0))
        expq.push_back({5'(i), snap[i], (i == NR - 1)});
  endtask

  task automatic run_dump(input vec_t v);
    int unsigned first_c = 0, done_c = 0, ndone = 0, nbeats = 0, exp_n;
    int unsigned stab_err = 0, busy_err = 0;
    bit          hold = 1'b0, wr_done = 1'b0, finished = 1'b0;
    beat_t       prev = '0, cur, e;
    fill(v.fill);
    build_exp(v.wr);
    exp_n = expq.size();
    tick();
    start = 1'b1;
    dif.dump_ready = ($urandom_range(0, 99) < v.ready_pct);
    @(negedge clk);
    for (int unsigned c = 1; c <= 3000 && !finished; c++) begin
      tick();
      start = (c == v.restart_at);
      dif.dump_ready = ($urandom_range(0, 99) < v.ready_pct);
      @(negedge clk);
      cur = {dif.dump_addr, dif.dump_data, dif.dump_last};
      if (hold && (!dif.dump_valid || cur != prev)) stab_err++;
      hold = dif.dump_valid && !dif.dump_ready;
      prev = cur;
      if (dif.dump_valid && first_c == 0) first_c = c;
      if (dif.dump_valid && dif.dump_ready) begin
        nbeats++;
        if (expq.size() == 0) chk({v.name, "_extra_beat"}, 64'(nbeats), 64'(exp_n));
        else begin
          e = expq.pop_front();
          chk({v.name, "_beat"}, 64'(cur), 64'(e));
        end
      end
      if (done_c == 0 && !busy) busy_err++;
      if (done) begin
        ndone++;
        if (done_c == 0) done_c = c;
      end else if (done_c != 0 && c == done_c + 1) begin
        chk({v.name, "_busy_after"}, 64'(busy), 64'(0));
        chk({v.name, "_addr_idle"}, 64'(rd_addr), 64'(0));
        finished = 1'b1;
      end
      if (v.wr && !wr_done && busy && !dif.dump_valid && !done && rd_addr == 5'd5) begin
        rf[6]   = 32'hDEADBEEF;
        wr_done = 1'b1;
      end
    end
    start = 1'b0;
    dif.dump_ready = 1'b0;
    chk({v.name, "_timeout"}, 64'(finished), 64'(1));
    chk({v.name, "_beats"}, 64'(nbeats), 64'(exp_n));
    chk({v.name, "_done_cnt"}, 64'(ndone), 64'(1));
    chk({v.name, "_stable"}, 64'(stab_err), 64'(0));
    chk({v.name, "_busy_during"}, 64'(busy_err), 64'(0));
    if (v.wr) chk({v.name, "_wr_seen"}, 64'(wr_done), 64'(1));
    if (v.exp_first != 0) chk({v.name, "_first"}, 64'(first_c), 64'(v.exp_first));
    if (v.exp_done != 0) chk({v.name, "_done_cyc"}, 64'(done_c), 64'(v.exp_done));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          found;
    int unsigned nd, nv, nb;
    beat_t       fb;
    bit          fb_set;

    tbl = '{
      '{"full_seq",   0, 100, 0,  1'b0, FULL_FIRST, FULL_DONE},
      '{"rand_ready", 0, 50,  0,  1'b0, 0,          0},
      '{"restart10",  0, 100, 10, 1'b0, FULL_FIRST, FULL_DONE},
      '{"mid_write",  0, 100, 0,  1'b1, FULL_FIRST, FULL_DONE},
      '{"rand_data",  1, 70,  0,  1'b0, 0,          0},
      '{"sparse",     2, 100, 0,  1'b0, SP_FIRST,   SP_DONE},
      '{"all_zero",   3, 100, 0,  1'b0, Z_FIRST,    Z_DONE},
      '{"rand_mix",   1, 30,  7,  1'b0, 0,          0}
    };

    // Reset state
    rst = 1'b1;
    start = 1'b0;
    dif.dump_ready = 1'b0;
    fill(0);
    repeat (2) tick();
    @(negedge clk);
    chk("rst_busy",  64'(busy), 64'(0));
    chk("rst_done",  64'(done), 64'(0));
    chk("rst_raddr", 64'(rd_addr), 64'(0));
    chk("rst_valid", 64'(dif.dump_valid), 64'(0));
    chk("rst_beat",  64'({dif.dump_addr, dif.dump_data, dif.dump_last}), 64'(0));
    tick();
    rst = 1'b0;

    foreach (tbl[k]) run_dump(tbl[k]);

    // Reset while beat addr 7 is held
    fill(0);
    tick();
    start = 1'b1;
    dif.dump_ready = 1'b1;
    found = 1'b0;
    for (int unsigned c = 1; c <= 200 && !found; c++) begin
      tick();
      start = 1'b0;
      @(negedge clk);
      if (dif.dump_valid && dif.dump_addr == 5'd7) found = 1'b1;
    end
    chk("rst7_reached", 64'(found), 64'(1));
    dif.dump_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst7_busy",  64'(busy), 64'(0));
    chk("rst7_done",  64'(done), 64'(0));
    chk("rst7_raddr", 64'(rd_addr), 64'(0));
    chk("rst7_valid", 64'(dif.dump_valid), 64'(0));
    chk("rst7_beat",  64'({dif.dump_addr, dif.dump_data, dif.dump_last}), 64'(0));
    nd = 0;
    nv = 0;
    dif.dump_ready = 1'b1;
    repeat (80) begin
      tick();
      @(negedge clk);
      if (done) nd++;
      if (dif.dump_valid) nv++;
    end
    chk("rst7_no_done", 64'(nd), 64'(0));
    chk("rst7_no_beat", 64'(nv), 64'(0));
    run_dump('{"after_rst", 0, 100, 0, 1'b0, FULL_FIRST, FULL_DONE});

    // Start during the done cycle is dropped; start in the next idle cycle is accepted
    fill(0);
    build_exp(1'b0);
    tick();
    start = 1'b1;
    dif.dump_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (FULL_DONE - 1) tick();
    start = 1'b1;
    @(negedge clk);
    chk("dc_done_pulse", 64'(done), 64'(1));
    tick();
    @(negedge clk);
    chk("dc_dropped", 64'(busy), 64'(0));
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("dc_accepted", 64'(busy), 64'(1));
    nb = 0;
    fb_set = 1'b0;
    fb = '0;
    found = 1'b0;
    for (int unsigned c = 1; c <= 300 && !found; c++) begin
      tick();
      @(negedge clk);
      if (dif.dump_valid && dif.dump_ready) begin
        nb++;
        if (!fb_set) begin
          fb = {dif.dump_addr, dif.dump_data, dif.dump_last};
          fb_set = 1'b1;
        end
      end
      if (done) found = 1'b1;
    end
    chk("dc_restart_done", 64'(found), 64'(1));
    chk("dc_restart_beats", 64'(nb), 64'(expq.size()));
    chk("dc_restart_first", 64'(fb), 64'(expq[0]));
    dif.dump_ready = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
